spi_monarch_16: RTL and testbench

16-bit SPI monarch (controller) that serialises one command word to the inertial sensor and captures its 16-bit response. It is the serial engine under the inertial interface sequencer. That sequencer issues `snd` with `cmd`, waits on `done`, then takes `resp[7:0]` into its holding registers. SPI mode 3: SCLK idles high, MOSI changes on SCLK fall, MISO is sampled on SCLK rise, MSB first.

---
 rtl/spi_monarch_16.sv | 98 +++++++++
 tb/tb_spi_monarch_16.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_monarch_16.sv
// 16-bit SPI mode-3 monarch: one command word out, one response word in, SCLK = clk/16.
// Build option SPI_LOOPBACK_EN: sample MOSI instead of the MISO pin (board self-test).
module spi_monarch_16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        snd,
   input  logic [15:0] cmd,
   input  logic        MISO,
   output logic        SS_n,
   output logic        SCLK,
   output logic        MOSI,
   output logic        done,
   output logic [15:0] resp
);

   typedef enum logic [1:0] {StIdle, StFront, StShift} state_e;

   // Divider value that holds SCLK high while idle and lands the first fall 5 clocks after SS_n drops.
   localparam logic [3:0] DivIdle = 4'b1011;

   state_e      r_state;
   logic [3:0]  r_div;
   logic [15:0] r_shft;
   logic [3:0]  r_bit_cnt;
   logic        r_miso_smpl;
   logic        r_ss_n;
   logic        r_done;
   logic        w_miso_src;

`ifdef SPI_LOOPBACK_EN
   logic w_unused_miso;
   assign w_unused_miso = MISO;
   assign w_miso_src    = r_shft[15];
`else
   assign w_miso_src    = MISO;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= StIdle;
         r_div       <= DivIdle;
         r_shft      <= 16'h0000;
         r_bit_cnt   <= 4'd0;
         r_miso_smpl <= 1'b0;
         r_ss_n      <= 1'b1;
         r_done      <= 1'b0;
      end else begin
         unique case (r_state)
            StIdle: begin
               r_div <= DivIdle;
               if (snd) begin
                  r_shft    <= cmd;
                  r_ss_n    <= 1'b0;
                  r_done    <= 1'b0;
                  r_bit_cnt <= 4'd0;
                  r_state   <= StFront;
               end
            end
            StFront: begin
               // The fall at the end of the porch is not a shift edge.
               r_div <= r_div + 4'd1;
               if (r_div == 4'b1111) begin
                  r_state <= StShift;
               end
            end
            StShift: begin
               r_div <= r_div + 4'd1;
               if (r_div == 4'b0111) begin
                  r_miso_smpl <= w_miso_src;
               end
               if (r_div == 4'b1111) begin
                  r_shft    <= {r_shft[14:0], r_miso_smpl};
                  r_bit_cnt <= r_bit_cnt + 4'd1;
                  if (r_bit_cnt == 4'd15) begin
                     // Reloading the divider keeps SCLK high: no 17th fall.
                     r_div   <= DivIdle;
                     r_ss_n  <= 1'b1;
                     r_done  <= 1'b1;
                     r_state <= StIdle;
                  end
               end
            end
            default: begin
               r_state <= StIdle;
               r_div   <= DivIdle;
               r_ss_n  <= 1'b1;
            end
         endcase
      end
   end

   assign SCLK = r_div[3];
   assign MOSI = r_shft[15];
   assign resp = r_shft;
   assign SS_n = r_ss_n;
   assign done = r_done;

endmodule

// File: tb/tb_spi_monarch_16.sv
// Scoreboard bench for spi_monarch_16 with a mode-3 sensor model.
// Stimulus pushes expectations; a monitor checks them when done rises.
module tb_spi_monarch_16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        snd = 1'b0;
   logic [15:0] cmd = 16'h0000;
   logic        MISO = 1'b0;
   logic        SS_n;
   logic        SCLK;
   logic        MOSI;
   logic        done;
   logic [15:0] resp;

   always #5 clk = ~clk;

   spi_monarch_16 u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .snd   (snd),
      .cmd   (cmd),
      .MISO  (MISO),
      .SS_n  (SS_n),
      .SCLK  (SCLK),
      .MOSI  (MOSI),
      .done  (done),
      .resp  (resp)
   );

   typedef struct {
      logic [15:0] cmd;
      logic [15:0] resp;
      int unsigned start;
   } txn_t;

   txn_t        sb_q[$];
   int unsigned n_chk  = 0;
   int unsigned n_fail = 0;
   int unsigned pcyc   = 0;

   always @(posedge clk) pcyc <= pcyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, pcyc);
      end
   endtask

   // Sensor model: drives MISO on SCLK falls, records MOSI and rise timing on rises.
   logic [15:0] sens_word = 16'h0000;
   logic [15:0] sens_sh   = 16'h0000;
   logic [15:0] mosi_cap  = 16'h0000;
   int          rcnt      = 0;
   int unsigned first_rise = 0;
   int unsigned last_rise  = 0;
   logic        per_err   = 1'b0;
   logic        prev_ss   = 1'b1;
   logic        prev_sclk = 1'b1;

   always @(negedge clk) begin
      if (prev_ss && !SS_n) begin
         sens_sh  = sens_word;
         rcnt     = 0;
         mosi_cap = 16'h0000;
         per_err  = 1'b0;
`ifdef SPI_LOOPBACK_EN
         MISO = 1'bx;
`else
         MISO = sens_sh[15];
`endif
      end else if (!SS_n) begin
         if (SCLK && !prev_sclk) begin
            mosi_cap = {mosi_cap[14:0], MOSI};
            if (rcnt == 0) first_rise = pcyc;
            else if (pcyc - last_rise != 16) per_err = 1'b1;
            last_rise = pcyc;
            rcnt++;
         end else if (!SCLK && prev_sclk && rcnt > 0) begin
            sens_sh = {sens_sh[14:0], 1'b0};
`ifdef SPI_LOOPBACK_EN
            MISO = 1'bx;
`else
            MISO = sens_sh[15];
`endif
         end
      end
      prev_ss   = SS_n;
      prev_sclk = SCLK;
   end

   // Monitor: one scoreboard entry per completed transaction.
   logic prev_done = 1'b0;
   always @(negedge clk) begin
      txn_t t;
      if (done && !prev_done) begin
         chk("done_expected", 32'(sb_q.size() > 0), 32'd1);
         if (sb_q.size() > 0) begin
            t = sb_q.pop_front();
            chk("resp", 32'(resp), 32'(t.resp));
            chk("mosi_stream", 32'(mosi_cap), 32'(t.cmd));
            chk("rise_count", rcnt, 32'd16);
            chk("rise_period_err", 32'(per_err), 32'd0);
            chk("first_rise", first_rise - t.start, 32'd14);
            chk("latency", pcyc - t.start, 32'd262);
            chk("ss_n_at_done", 32'(SS_n), 32'd1);
         end
      end
      prev_done = done;
   end

   // Caller is at a negedge; returns one negedge later with snd dropped.
   task automatic send(input logic [15:0] c, input logic [15:0] sens);
      txn_t t;
      sens_word = sens;
      cmd       = c;
      snd       = 1'b1;
      t.cmd     = c;
`ifdef SPI_LOOPBACK_EN
      t.resp    = c;
`else
      t.resp    = sens;
`endif
      t.start   = pcyc;
      sb_q.push_back(t);
      @(negedge clk);
      snd = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int k = 0;
      while (!done && k < bound) begin
         @(negedge clk);
         k++;
      end
      chk("done_within_bound", 32'(done), 32'd1);
   endtask

   task automatic wait_rise(input int n, input int bound);
      int k = 0;
      repeat (2) @(negedge clk);
      while (rcnt < n && k < bound) begin
         @(negedge clk);
         k++;
      end
      chk("rise_within_bound", 32'(rcnt >= n), 32'd1);
   endtask

   initial begin
      int cnt;
      logic [15:0] exp_hold;

      // Reset and idle.
      repeat (3) @(negedge clk);
      chk("reset_outputs", {SS_n, SCLK, done, MOSI, resp}, {1'b1, 1'b1, 1'b0, 1'b0, 16'h0000});
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      chk("idle_static", {SS_n, SCLK, done, MOSI, resp}, {1'b1, 1'b1, 1'b0, 1'b0, 16'h0000});

      // Single transfer.
      send(16'h0D02, 16'hA5C3);
      chk("ss_low_t1", 32'(SS_n), 32'd0);
      wait_done(400);

      // Ignored snd mid-transfer, then done stickiness.
      @(negedge clk);
      send(16'h1053, 16'h3C96);
      wait_rise(5, 400);
      cmd = 16'hFFFF;
      snd = 1'b1;
      @(negedge clk);
      snd = 1'b0;
      wait_done(400);
      cnt = 0;
      repeat (50) begin
         @(negedge clk);
         if (done && SS_n && SCLK) cnt++;
      end
      chk("done_sticky_idle", cnt, 32'd50);
`ifdef SPI_LOOPBACK_EN
      exp_hold = 16'h1053;
`else
      exp_hold = 16'h3C96;
`endif
      chk("resp_hold", 32'(resp), 32'(exp_hold));

      // Back-to-back: snd on the cycle done is high.
      @(negedge clk);
      send(16'h5AF0, 16'h0F0F);
      wait_done(400);
      send(16'hA412, 16'hC3A5);
      chk("b2b_done_clear", 32'(done), 32'd0);
      chk("b2b_ss_low", 32'(SS_n), 32'd0);
      wait_done(400);

      // Asynchronous reset during bit 7, then a clean transfer.
      @(negedge clk);
      send(16'h7E81, 16'h1234);
      wait_rise(7, 400);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset", {SS_n, SCLK, done, MOSI, resp}, {1'b1, 1'b1, 1'b0, 1'b0, 16'h0000});
      sb_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(16'h2B4D, 16'hE817);
      wait_done(400);

      // Loopback-flavoured vector (resp == cmd when SPI_LOOPBACK_EN is set).
      @(negedge clk);
      send(16'h1460, 16'h9B2E);
      wait_done(400);

      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
